// File: rtl/csirx_pkg.sv
// csirx_pkg: CSI-2 data type codes and packet sequencer state encoding
package csirx_pkg;
  localparam logic [5:0] DT_FS       = 6'h00;
  localparam logic [5:0] DT_FE       = 6'h01;
  localparam logic [5:0] DT_LS       = 6'h02;
  localparam logic [5:0] DT_LE       = 6'h03;
  localparam logic [5:0] DT_LONG_MIN = 6'h10;
  localparam logic [5:0] DT_RAW8     = 6'h2A;
  localparam logic [5:0] DT_RAW10    = 6'h2B;
  typedef enum logic [2:0] {IDLE, HDR1, PAYLOAD, FOOTER, WAIT_END} state_t;
endpackage

// File: rtl/csirx_axis_outreg.sv
// csirx_axis_outreg: single-entry AXI4-Stream output register that drops words arriving while full
module csirx_axis_outreg #(
  parameter int W = 16,
  parameter int K = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic [K-1:0] in_keep,
  input  logic         in_last,
  input  logic         in_user,
  output logic         loaded,
  output logic         overflow,
  output logic         m_axis_tvalid,
  output logic [W-1:0] m_axis_tdata,
  output logic [K-1:0] m_axis_tkeep,
  output logic         m_axis_tlast,
  output logic         m_axis_tuser,
  input  logic         m_axis_tready
);
  assign loaded = in_valid && (!m_axis_tvalid || m_axis_tready);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      overflow      <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
    end else begin
      overflow <= in_valid && !loaded;
      if (loaded) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= in_data;
        m_axis_tkeep  <= in_keep;
        m_axis_tlast  <= in_last;
        m_axis_tuser  <= in_user;
      end else if (m_axis_tready) m_axis_tvalid <= 1'b0;
    end
endmodule

// File: rtl/csirx_packet_ctrl.sv
// csirx_packet_ctrl: parses CSI-2 packets from aligned lane words, tracks frames, streams accepted payload lines
module csirx_packet_ctrl
  import csirx_pkg::*;
#(
  parameter int         N_DATA_LANES = 2,
  parameter logic [5:0] ACCEPT_DT    = 6'h2B,
  parameter logic [1:0] ACCEPT_VC    = 2'd0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [8*N_DATA_LANES-1:0] word_in,
  input  logic                      word_valid,
  input  logic                      burst_active,
  output logic                      m_axis_tvalid,
  output logic [8*N_DATA_LANES-1:0] m_axis_tdata,
  output logic [N_DATA_LANES-1:0]   m_axis_tkeep,
  output logic                      m_axis_tlast,
  output logic                      m_axis_tuser,
  input  logic                      m_axis_tready,
  output logic                      frame_active,
  output logic [15:0]               frame_num,
  output logic [15:0]               line_count,
  output logic                      err_truncated,
  output logic                      err_overflow
);
  localparam int K = N_DATA_LANES;
  state_t      state;
  logic [7:0]  di, wc_l;
  logic [15:0] rem;
  logic        wc_odd, fwd, sof_pending, loaded;
  logic [15:0] wc_full;
  logic [16:0] wc_p1;
  logic        pay_valid, pay_last;
  logic [K-1:0] pay_keep;
  assign wc_full   = {word_in[7:0], wc_l};
  assign wc_p1     = {1'b0, wc_full} + 17'd1;
  assign pay_last  = rem == 16'd1;
  assign pay_valid = state == PAYLOAD && word_valid && burst_active && fwd;
  assign pay_keep  = (pay_last && wc_odd) ? K'(1) : {K{1'b1}};
  csirx_axis_outreg #(.W(8*K), .K(K)) u_outreg (
    .clk(clk), .reset(reset),
    .in_valid(pay_valid), .in_data(word_in), .in_keep(pay_keep),
    .in_last(pay_last), .in_user(sof_pending),
    .loaded(loaded), .overflow(err_overflow),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser), .m_axis_tready(m_axis_tready)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state         <= IDLE;
      di            <= '0;
      wc_l          <= '0;
      wc_odd        <= 1'b0;
      rem           <= '0;
      fwd           <= 1'b0;
      frame_active  <= 1'b0;
      frame_num     <= '0;
      line_count    <= '0;
      sof_pending   <= 1'b0;
      err_truncated <= 1'b0;
    end else begin
      err_truncated <= 1'b0;
      if (loaded && sof_pending) sof_pending <= 1'b0;
      if (loaded && pay_last) line_count <= line_count + 16'd1;
      case (state)
        IDLE:
          if (word_valid) begin
            di    <= word_in[7:0];
            wc_l  <= word_in[15:8];
            state <= HDR1;
          end
        HDR1:
          if (!burst_active) begin
            err_truncated <= 1'b1;
            state         <= IDLE;
          end else if (word_valid) begin
            wc_odd <= wc_full[0];
            rem    <= wc_p1[16:1];
            fwd    <= di[5:0] == ACCEPT_DT && di[7:6] == ACCEPT_VC && frame_active;
            if (di[5:0] < DT_LONG_MIN) begin
              if (di[7:6] == ACCEPT_VC && di[5:0] == DT_FS) begin
                frame_active <= 1'b1;
                frame_num    <= wc_full;
                line_count   <= '0;
                sof_pending  <= 1'b1;
              end else if (di[7:6] == ACCEPT_VC && di[5:0] == DT_FE) frame_active <= 1'b0;
              state <= WAIT_END;
            end else state <= wc_full == 16'd0 ? FOOTER : PAYLOAD;
          end
        PAYLOAD:
          if (!burst_active) begin
            err_truncated <= 1'b1;
            state         <= IDLE;
          end else if (word_valid) begin
            rem <= rem - 16'd1;
            if (pay_last) state <= FOOTER;
          end
        FOOTER:
          if (!burst_active) begin
            err_truncated <= 1'b1;
            state         <= IDLE;
          end else if (word_valid) state <= WAIT_END;
        default:
          if (!burst_active) state <= IDLE;
      endcase
    end
endmodule
